ball_motion: RTL and testbench

BALL_MOTION -- requirements
Module: ball_motion

---
 rtl/ball_motion_if.sv | 31 +++
 rtl/ball_motion.sv | 215 +++++++++++++++++++++
 tb/tb_ball_motion.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_motion_if.sv
// ball_motion_if: groups the frame/kick controls and the sprite-position /
// status outputs of the bouncing-ball motion engine.
//   frame_tick    : one-cycle pulse per video frame (master -> slave)
//   kick          : kick request, with kick_vx/kick_vy signed Q5.4 velocities
//   x0, y0        : sprite origin in integer pixels (slave -> master)
//   hit_wall      : one-cycle pulse when the ball met a side wall
//   hit_floor     : one-cycle pulse when the ball met the floor
//   busy          : frame update in progress
//   frame_overrun : sticky flag, a frame_tick arrived while busy
interface ball_motion_if;
    logic        frame_tick;
    logic        kick;
    logic [9:0]  kick_vx;
    logic [9:0]  kick_vy;
    logic [10:0] x0;
    logic [10:0] y0;
    logic        hit_wall;
    logic        hit_floor;
    logic        busy;
    logic        frame_overrun;

    modport master (
        output frame_tick, kick, kick_vx, kick_vy,
        input  x0, y0, hit_wall, hit_floor, busy, frame_overrun
    );

    modport slave (
        input  frame_tick, kick, kick_vx, kick_vy,
        output x0, y0, hit_wall, hit_floor, busy, frame_overrun
    );
endinterface

// File: rtl/ball_motion.sv
// ball_motion: per-frame ball physics for a 16x16 sprite. Each frame_tick
// runs a five-state update (velocity, position, collision, output) on Q11.4
// position and Q5.4 velocity, with gravity, wall/floor bounces and kicks.
//   clk   : the single clock
//   reset : synchronous active-high reset
//   bus   : ball_motion_if slave (frame_tick, kick*, x0/y0, hits, status)
module ball_motion #(
    parameter int X_INIT   = 312,
    parameter int Y_INIT   = 100,
    parameter int X_MAX    = 624,
    parameter int GROUND_Y = 400,
    parameter int GRAV     = 2,
    parameter int VMAX     = 255,
    parameter int REST_V   = 8
) (
    input  logic         clk,
    input  logic         reset,
    ball_motion_if.slave bus
);
    localparam int unsigned PW  = 16;
    localparam int unsigned PSW = PW + 1;
    localparam int unsigned VW  = 10;
    localparam int unsigned SW  = 12;
    localparam int unsigned OW  = 11;

    localparam logic signed [PW-1:0] PX_INIT = PW'(X_INIT * 16);
    localparam logic signed [PW-1:0] PY_INIT = PW'(Y_INIT * 16);
    localparam logic signed [PW-1:0] PX_MAX  = PW'(X_MAX * 16);
    localparam logic signed [PW-1:0] PY_GND  = PW'(GROUND_Y * 16);
    localparam logic signed [SW-1:0] GRAV_S  = SW'(GRAV);
    localparam logic signed [SW-1:0] VMAX_S  = SW'(VMAX);
    localparam logic signed [VW-1:0] REST_S  = VW'(REST_V);

    typedef enum logic [2:0] {S_IDLE, S_VEL, S_POS, S_COL, S_OUT} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic signed [PW-1:0] r_px, r_py;
    logic signed [VW-1:0] r_vx, r_vy;
    logic signed [VW-1:0] r_kvx, r_kvy;
    logic                 r_pend;
    logic [OW-1:0]        r_x0, r_y0;
    logic                 r_hit_wall, r_hit_floor, r_overrun;
    logic                 w_busy, w_ld_vel, w_ld_pos, w_ld_col;

    // Clamp a widened velocity to +/-VMAX
    function automatic logic signed [VW-1:0] sat_v(input logic signed [SW-1:0] v);
        logic signed [VW-1:0] r;
        if (v > VMAX_S)       r = VW'(VMAX_S);
        else if (v < -VMAX_S) r = VW'(-VMAX_S);
        else                  r = VW'(v);
        return r;
    endfunction

    // Clamp a widened position sum so px/py never wrap
    function automatic logic signed [PW-1:0] sat_p(input logic signed [PSW-1:0] s);
        logic signed [PW-1:0] r;
        if (s[PSW-1] != s[PW-1])
            r = s[PSW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
        else
            r = PW'(s);
        return r;
    endfunction

    // Reverse direction and keep 3/4 of the speed: -(v - (v >>> 2))
    function automatic logic signed [VW-1:0] bounce(input logic signed [VW-1:0] v);
        logic signed [SW-1:0] w;
        w = SW'(v) - (SW'(v) >>> 2);
        return VW'(-w);
    endfunction

    // Kill tiny post-bounce speeds so the ball comes to rest
    function automatic logic signed [VW-1:0] settle(input logic signed [VW-1:0] v);
        return (v > -REST_S && v < REST_S) ? '0 : v;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; ticks outside S_IDLE are dropped
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.frame_tick) w_state_nxt = S_VEL;
            S_VEL:   w_state_nxt = S_POS;
            S_POS:   w_state_nxt = S_COL;
            S_COL:   w_state_nxt = S_OUT;
            S_OUT:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State decode: busy and per-stage load enables
    always_comb begin
        w_busy   = 1'b1;
        w_ld_vel = 1'b0;
        w_ld_pos = 1'b0;
        w_ld_col = 1'b0;
        case (r_state)
            S_IDLE:  w_busy   = 1'b0;
            S_VEL:   w_ld_vel = 1'b1;
            S_POS:   w_ld_pos = 1'b1;
            S_COL:   w_ld_col = 1'b1;
            S_OUT:   w_busy   = 1'b1;
            default: w_busy   = 1'b0;
        endcase
    end

    // Velocity stage: a pending kick replaces gravity for this frame
    logic signed [SW-1:0] w_vy_grav;
    logic signed [VW-1:0] w_vx_vel, w_vy_vel;
    always_comb begin
        w_vy_grav = SW'(r_vy) + GRAV_S;
        if (r_pend) begin
            w_vx_vel = sat_v(SW'(r_kvx));
            w_vy_vel = sat_v(SW'(r_kvy));
        end else begin
            w_vx_vel = sat_v(SW'(r_vx));
            w_vy_vel = sat_v(w_vy_grav);
        end
    end

    // Position stage
    logic signed [PW-1:0] w_px_pos, w_py_pos;
    assign w_px_pos = sat_p(PSW'(r_px) + PSW'(r_vx));
    assign w_py_pos = sat_p(PSW'(r_py) + PSW'(r_vy));

    // Collision stage: clamp to the playfield and bounce
    logic signed [PW-1:0] w_px_col, w_py_col;
    logic signed [VW-1:0] w_vx_col, w_vy_col;
    logic                 w_hw, w_hf;
    always_comb begin
        w_px_col = r_px;
        w_py_col = r_py;
        w_vx_col = r_vx;
        w_vy_col = r_vy;
        w_hw     = 1'b0;
        w_hf     = 1'b0;
        if (r_px[PW-1]) begin
            w_px_col = '0;
            w_vx_col = bounce(r_vx);
            w_hw     = 1'b1;
        end else if (r_px > PX_MAX) begin
            w_px_col = PX_MAX;
            w_vx_col = bounce(r_vx);
            w_hw     = 1'b1;
        end
        if (r_py > PY_GND) begin
            w_py_col = PY_GND;
            w_vy_col = settle(bounce(r_vy));
            w_hf     = 1'b1;
        end else if (r_py[PW-1]) begin
            w_py_col = '0;
            w_vy_col = settle(bounce(r_vy));
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_px        <= PX_INIT;
            r_py        <= PY_INIT;
            r_vx        <= '0;
            r_vy        <= '0;
            r_kvx       <= '0;
            r_kvy       <= '0;
            r_pend      <= 1'b0;
            r_x0        <= OW'(X_INIT);
            r_y0        <= OW'(Y_INIT);
            r_hit_wall  <= 1'b0;
            r_hit_floor <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // A kick in S_VEL wins over the clear, so it is kept for next frame
            if (bus.kick) begin
                r_kvx  <= bus.kick_vx;
                r_kvy  <= bus.kick_vy;
                r_pend <= 1'b1;
            end else if (w_ld_vel) begin
                r_pend <= 1'b0;
            end
            if (w_ld_vel) begin
                r_vx <= w_vx_vel;
                r_vy <= w_vy_vel;
            end
            if (w_ld_pos) begin
                r_px <= w_px_pos;
                r_py <= w_py_pos;
            end
            r_hit_wall  <= 1'b0;
            r_hit_floor <= 1'b0;
            if (w_ld_col) begin
                r_px        <= w_px_col;
                r_py        <= w_py_col;
                r_vx        <= w_vx_col;
                r_vy        <= w_vy_col;
                r_x0        <= w_px_col[14:4];
                r_y0        <= w_py_col[14:4];
                r_hit_wall  <= w_hw;
                r_hit_floor <= w_hf;
            end
            if (bus.frame_tick && w_busy) r_overrun <= 1'b1;
        end
    end

    assign bus.x0            = r_x0;
    assign bus.y0            = r_y0;
    assign bus.hit_wall      = r_hit_wall;
    assign bus.hit_floor     = r_hit_floor;
    assign bus.busy          = w_busy;
    assign bus.frame_overrun = r_overrun;
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: self-checking bench for ball_motion. An integer reference
// model predicts each frame's outcome; predictions are queued at the tick and
// compared when the DUT presents its S_OUT cycle.
module tb_ball_motion;
    logic clk;
    logic reset;

    ball_motion_if u_if ();

    ball_motion u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x0;
        int y0;
        bit hw;
        bit hf;
    } exp_t;

    typedef struct {
        bit do_kick;
        int kvx;
        int kvy;
        int nframes;
        int ex0;
        int ey0;
        int ewall;
        int efloor;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_wall;
    int   n_floor;
    bit   last_hf;
    exp_t sb_q[$];
    vec_t vecs[7];

    // Reference model state (Q4 fixed point held in plain ints)
    int m_px, m_py, m_vx, m_vy, m_kvx, m_kvy;
    bit m_pend;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int msat(input int v);
        if (v > 255) return 255;
        if (v < -255) return -255;
        return v;
    endfunction

    // Negate and keep v minus floor(v/4)
    function automatic int mdamp(input int v);
        int q;
        q = (v >= 0) ? v / 4 : -((-v + 3) / 4);
        return q - v;
    endfunction

    function automatic int mrest(input int v);
        if (v > -8 && v < 8) return 0;
        return v;
    endfunction

    task automatic model_reset();
        m_px = 312 * 16; m_py = 100 * 16;
        m_vx = 0; m_vy = 0; m_kvx = 0; m_kvy = 0; m_pend = 0;
    endtask

    task automatic model_frame(output exp_t e);
        if (m_pend) begin
            m_vx = msat(m_kvx); m_vy = msat(m_kvy); m_pend = 0;
        end else begin
            m_vy = msat(m_vy + 2);
        end
        m_px = m_px + m_vx;
        m_py = m_py + m_vy;
        e.hw = 0; e.hf = 0;
        if (m_px < 0) begin
            m_px = 0; m_vx = mdamp(m_vx); e.hw = 1;
        end else if (m_px > 624 * 16) begin
            m_px = 624 * 16; m_vx = mdamp(m_vx); e.hw = 1;
        end
        if (m_py > 400 * 16) begin
            m_py = 400 * 16; m_vy = mrest(mdamp(m_vy)); e.hf = 1;
        end else if (m_py < 0) begin
            m_py = 0; m_vy = mrest(mdamp(m_vy));
        end
        e.x0 = m_px / 16;
        e.y0 = m_py / 16;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        u_if.frame_tick = 1'b0;
        u_if.kick = 1'b0;
        step();
        step();
        reset = 1'b0;
        model_reset();
        chk("rst_x0", u_if.x0, 312);
        chk("rst_y0", u_if.y0, 100);
        chk("rst_busy", u_if.busy, 0);
        chk("rst_hits", {u_if.hit_wall, u_if.hit_floor}, 0);
        chk("rst_overrun", u_if.frame_overrun, 0);
    endtask

    task automatic drive_kick(input int kvx, input int kvy);
        u_if.kick = 1'b1;
        u_if.kick_vx = 10'(kvx);
        u_if.kick_vy = 10'(kvy);
        step();
        u_if.kick = 1'b0;
        m_kvx = kvx; m_kvy = kvy; m_pend = 1;
    endtask

    // One frame: tick, then check the four update cycles and the return to idle.
    // kick_at / tick_at pulse kick or an extra tick on that update cycle (0 = none).
    task automatic do_frame(input int kick_at, input int kvx, input int kvy, input int tick_at);
        int   px0, py0;
        exp_t e;
        exp_t got;
        px0 = int'(u_if.x0);
        py0 = int'(u_if.y0);
        u_if.frame_tick = 1'b1;
        step();
        u_if.frame_tick = 1'b0;
        model_frame(e);
        sb_q.push_back(e);
        for (int c = 1; c <= 4; c++) begin
            chk("busy_upd", u_if.busy, 1);
            if (c < 4) begin
                chk("x0_hold", u_if.x0, px0);
                chk("y0_hold", u_if.y0, py0);
                chk("hw_early", u_if.hit_wall, 0);
                chk("hf_early", u_if.hit_floor, 0);
            end else begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 0, 1);
                end else begin
                    got = sb_q.pop_front();
                    chk("out_x0", u_if.x0, got.x0);
                    chk("out_y0", u_if.y0, got.y0);
                    chk("out_hw", u_if.hit_wall, got.hw);
                    chk("out_hf", u_if.hit_floor, got.hf);
                end
                if (u_if.hit_wall) n_wall++;
                if (u_if.hit_floor) n_floor++;
                last_hf = u_if.hit_floor;
            end
            if (c == kick_at) begin
                u_if.kick = 1'b1;
                u_if.kick_vx = 10'(kvx);
                u_if.kick_vy = 10'(kvy);
                m_kvx = kvx; m_kvy = kvy; m_pend = 1;
            end
            if (c == tick_at) u_if.frame_tick = 1'b1;
            step();
            u_if.kick = 1'b0;
            u_if.frame_tick = 1'b0;
        end
        chk("busy_done", u_if.busy, 0);
        chk("hw_after", u_if.hit_wall, 0);
        chk("hf_after", u_if.hit_floor, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        u_if.frame_tick = 1'b0;
        u_if.kick = 1'b0;
        u_if.kick_vx = '0;
        u_if.kick_vy = '0;
        n_wall = 0;
        n_floor = 0;
        last_hf = 0;

        // {kick, kvx, kvy, frames, x0, y0, wall pulses, floor pulses}
        vecs[0] = '{0,    0,   0,  8, 312, 104, 0, 0};
        vecs[1] = '{1,   64,   0,  1, 316, 100, 0, 0};
        vecs[2] = '{1,  255,   0, 20, 624, 123, 1, 0};
        vecs[3] = '{1,    0, 255, 19, 312, 400, 0, 1};
        vecs[4] = '{1, -255,   0, 20,   0, 123, 1, 0};
        vecs[5] = '{1,  511,   0,  1, 327, 100, 0, 0};
        vecs[6] = '{1, -512,   0,  1, 296, 100, 0, 0};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            n_wall = 0;
            n_floor = 0;
            if (vecs[i].do_kick) drive_kick(vecs[i].kvx, vecs[i].kvy);
            repeat (vecs[i].nframes) do_frame(0, 0, 0, 0);
            chk($sformatf("vec%0d_x0", i), u_if.x0, vecs[i].ex0);
            chk($sformatf("vec%0d_y0", i), u_if.y0, vecs[i].ey0);
            chk($sformatf("vec%0d_walls", i), n_wall, vecs[i].ewall);
            chk($sformatf("vec%0d_floors", i), n_floor, vecs[i].efloor);
            chk($sformatf("vec%0d_overrun", i), u_if.frame_overrun, 0);
        end

        // A second kick before the frame overwrites the first
        do_reset();
        drive_kick(64, 0);
        drive_kick(-64, 0);
        do_frame(0, 0, 0, 0);
        chk("kick_overwrite_x0", u_if.x0, 308);

        // Kick during S_VEL is held for the following frame
        do_reset();
        do_frame(1, 160, 0, 0);
        chk("kick_vel_f1_x0", u_if.x0, 312);
        chk("kick_vel_f1_y0", u_if.y0, 100);
        do_frame(0, 0, 0, 0);
        chk("kick_vel_f2_x0", u_if.x0, 322);

        // Tick during an update is ignored and flags an overrun
        do_reset();
        do_frame(0, 0, 0, 2);
        chk("ovr_flag", u_if.frame_overrun, 1);
        chk("ovr_x0", u_if.x0, 312);
        chk("ovr_y0", u_if.y0, 100);
        repeat (6) begin
            step();
            chk("ovr_no_second_update", u_if.busy, 0);
        end
        do_frame(0, 0, 0, 0);
        chk("ovr_sticky", u_if.frame_overrun, 1);

        // Reset in S_POS aborts the update and drops the pending kick
        do_reset();
        drive_kick(255, 0);
        u_if.frame_tick = 1'b1;
        step();
        u_if.frame_tick = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        chk("rpos_busy", u_if.busy, 0);
        chk("rpos_x0", u_if.x0, 312);
        chk("rpos_y0", u_if.y0, 100);
        repeat (5) begin
            chk("rpos_no_hit", {u_if.hit_wall, u_if.hit_floor}, 0);
            chk("rpos_idle", u_if.busy, 0);
            step();
        end
        do_frame(0, 0, 0, 0);
        chk("rpos_kick_dropped", u_if.x0, 312);

        // Tick and kick coincident with reset are discarded
        reset = 1'b1;
        u_if.frame_tick = 1'b1;
        u_if.kick = 1'b1;
        u_if.kick_vx = 10'(64);
        u_if.kick_vy = 10'(0);
        step();
        reset = 1'b0;
        u_if.frame_tick = 1'b0;
        u_if.kick = 1'b0;
        model_reset();
        step();
        chk("rcoin_busy", u_if.busy, 0);
        do_frame(0, 0, 0, 0);
        chk("rcoin_x0", u_if.x0, 312);
        chk("rcoin_y0", u_if.y0, 100);

        // Floor bounces decay until the ball rests on the ground
        do_reset();
        n_floor = 0;
        drive_kick(0, 255);
        repeat (1200) do_frame(0, 0, 0, 0);
        chk("rest_y0", u_if.y0, 400);
        chk("rest_x0", u_if.x0, 312);
        chk("rest_floor_pulse", last_hf, 1);

        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
